// File: rtl/reg_file_pkg.sv
// Shared constants and address qualification for the register file slice.
package reg_file_pkg;

    localparam int unsigned DATA_W_DEF   = 32;
    localparam int unsigned ADDR_W_DEF   = 5;
    localparam int unsigned NUM_REGS_DEF = 32;

    // An address is usable when it is implemented and is not the hardwired zero register.
    function automatic logic addr_valid(
        input int unsigned addr,
        input int unsigned num_regs,
        input bit          zero_reg
    );
        return (addr < num_regs) && !(zero_reg && (addr == 0));
    endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Busy scoreboard: per-register pending-producer bits, issue handshake and busy counter.
module reg_scoreboard
    import reg_file_pkg::*;
#(
    parameter int unsigned ADDR_W   = ADDR_W_DEF,
    parameter int unsigned NUM_REGS = NUM_REGS_DEF,
    parameter bit          ZERO_REG = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                issue_en,
    input  logic [ADDR_W-1:0]   issue_addr,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_addr,
    output logic [NUM_REGS-1:0] busy,
    output logic                issue_ready,
    output logic [ADDR_W:0]     busy_count
);

    localparam logic [ADDR_W:0] CNT_MAX = (ADDR_W + 1)'(NUM_REGS);

    logic                wr_valid;
    logic                iss_valid;
    logic                iss_busy;
    logic                wr_busy;
    logic                same_addr;
    logic                accept;
    logic [NUM_REGS-1:0] wr_hit;
    logic [NUM_REGS-1:0] iss_hit;

    always_comb begin
        wr_valid  = wr_en && addr_valid(32'(wr_addr), NUM_REGS, ZERO_REG);
        iss_valid = addr_valid(32'(issue_addr), NUM_REGS, ZERO_REG);
        wr_hit    = '0;
        iss_hit   = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            wr_hit[i]  = wr_valid && (wr_addr == ADDR_W'(i));
            iss_hit[i] = iss_valid && (issue_addr == ADDR_W'(i));
        end
        iss_busy    = |(busy & iss_hit);
        wr_busy     = |(busy & wr_hit);
        same_addr   = wr_valid && (wr_addr == issue_addr);
        issue_ready = !iss_busy || same_addr;
        accept      = issue_en && iss_valid && issue_ready;
    end

    // Set after clear so a same-cycle re-reservation leaves the register busy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy       <= '0;
            busy_count <= '0;
        end else begin
            busy <= (busy & ~wr_hit) | (accept ? iss_hit : '0);
            if (accept && !wr_busy && (busy_count != CNT_MAX))
                busy_count <= busy_count + 1'b1;
            else if (wr_busy && !accept && (busy_count != '0))
                busy_count <= busy_count - 1'b1;
        end
    end

endmodule

// File: rtl/reg_file_sb.sv
// Parametrised register file with N combinational read ports, one write-back port,
// optional same-cycle write bypass and a busy scoreboard for multi-cycle producers.
module reg_file_sb
    import reg_file_pkg::*;
#(
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter int unsigned ADDR_W   = ADDR_W_DEF,
    parameter int unsigned NUM_REGS = NUM_REGS_DEF,
    parameter int unsigned NUM_RD   = 2,
    parameter int unsigned BYPASS   = 1,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     issue_en,
    input  logic [ADDR_W-1:0]        issue_addr,
    output logic                     issue_ready,
    output logic [ADDR_W:0]          busy_count
);

    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [NUM_REGS-1:0] busy;
    logic                wr_valid;

    assign wr_valid = wr_en && addr_valid(32'(wr_addr), NUM_REGS, ZERO_REG != 0);

    reg_scoreboard #(
        .ADDR_W   (ADDR_W),
        .NUM_REGS (NUM_REGS),
        .ZERO_REG (ZERO_REG != 0)
    ) u_scoreboard (
        .clk         (clk),
        .rst         (rst),
        .issue_en    (issue_en),
        .issue_addr  (issue_addr),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .busy        (busy),
        .issue_ready (issue_ready),
        .busy_count  (busy_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_REGS; i++)
                regs[i] <= '0;
        end else if (wr_valid) begin
            for (int unsigned i = 0; i < NUM_REGS; i++)
                if (wr_addr == ADDR_W'(i))
                    regs[i] <= wr_data;
        end
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              bsy;

        assign addr = rd_addr[p*ADDR_W +: ADDR_W];

        // A bypassed write also clears busy, so the bypass path reports not-busy.
        always_comb begin
            data = '0;
            bsy  = 1'b0;
            if (addr_valid(32'(addr), NUM_REGS, ZERO_REG != 0)) begin
                if ((BYPASS != 0) && wr_valid && (wr_addr == addr)) begin
                    data = wr_data;
                end else begin
                    for (int unsigned i = 0; i < NUM_REGS; i++) begin
                        if (addr == ADDR_W'(i)) begin
                            data = regs[i];
                            bsy  = busy[i];
                        end
                    end
                end
            end
        end

        assign rd_data[p*DATA_W +: DATA_W] = data;
        assign rd_busy[p]                  = bsy;
    end

endmodule

// File: tb/tb_reg_file_sb.sv
// Self-checking bench: default instance, a no-bypass instance and a 16-register instance
// share stimulus; expectations are queued as stimulus is driven and popped at sampling.
module tb_reg_file_sb;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [9:0]  rd_addr = '0;
    logic        wr_en = 1'b0;
    logic [4:0]  wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic        issue_en = 1'b0;
    logic [4:0]  issue_addr = '0;

    logic [63:0] rd_data_a, rd_data_b, rd_data_c;
    logic [1:0]  rd_busy_a, rd_busy_b, rd_busy_c;
    logic        ready_a, ready_b, ready_c;
    logic [5:0]  count_a, count_b, count_c;

    logic [31:0] a_d0, a_d1, b_d0, b_d1, c_d0, c_d1;
    assign a_d0 = rd_data_a[31:0];
    assign a_d1 = rd_data_a[63:32];
    assign b_d0 = rd_data_b[31:0];
    assign b_d1 = rd_data_b[63:32];
    assign c_d0 = rd_data_c[31:0];
    assign c_d1 = rd_data_c[63:32];

    always #5 clk = ~clk;

    reg_file_sb dut (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_a), .rd_busy(rd_busy_a),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .issue_en(issue_en),
        .issue_addr(issue_addr), .issue_ready(ready_a), .busy_count(count_a)
    );

    reg_file_sb #(.BYPASS(0)) dut_nb (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .issue_en(issue_en),
        .issue_addr(issue_addr), .issue_ready(ready_b), .busy_count(count_b)
    );

    reg_file_sb #(.NUM_REGS(16)) dut16 (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_c), .rd_busy(rd_busy_c),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .issue_en(issue_en),
        .issue_addr(issue_addr), .issue_ready(ready_c), .busy_count(count_c)
    );

    typedef struct {
        string       name;
        logic [31:0] exp;
    } exp_t;

    exp_t        q[$];
    exp_t        e;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] mreg [32];
    int          mcount;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rd(input int a0, input int a1);
        rd_addr = {5'(a1), 5'(a0)};
    endtask

    task automatic test_reset();
        for (int a = 0; a < 32; a++) begin
            set_rd(a, 31 - a);
            #1;
            q.push_back('{name: "rst_rd0", exp: 32'h0});
            q.push_back('{name: "rst_rd1", exp: 32'h0});
            q.push_back('{name: "rst_busy", exp: 32'h0});
            e = q.pop_front(); checks++;
            if (a_d0 !== e.exp) begin errors++; $display("FAIL %s a=%0d: got %h want %h", e.name, a, a_d0, e.exp); end
            e = q.pop_front(); checks++;
            if (a_d1 !== e.exp) begin errors++; $display("FAIL %s a=%0d: got %h want %h", e.name, a, a_d1, e.exp); end
            e = q.pop_front(); checks++;
            if ({30'b0, rd_busy_a} !== e.exp) begin errors++; $display("FAIL %s a=%0d: got %h want %h", e.name, a, rd_busy_a, e.exp); end
        end
        q.push_back('{name: "rst_count", exp: 32'h0});
        q.push_back('{name: "rst_ready", exp: 32'h1});
        e = q.pop_front(); checks++;
        if ({26'b0, count_a} !== e.exp) begin errors++; $display("FAIL %s: got %h want %h", e.name, count_a, e.exp); end
        e = q.pop_front(); checks++;
        if ({31'b0, ready_a} !== e.exp) begin errors++; $display("FAIL %s: got %h want %h", e.name, ready_a, e.exp); end

        step();
        rst = 1'b0;
        set_rd(6, 5);
        wr_en = 1'b1; wr_addr = 5'd6; wr_data = 32'h55;
        step();
        wr_en = 1'b0;
        #2;
        q.push_back('{name: "pre_async_r6", exp: 32'h55});
        e = q.pop_front(); checks++;
        if (a_d0 !== e.exp) begin errors++; $display("FAIL %s: got %h want %h", e.name, a_d0, e.exp); end
        // Reset raised away from any clock edge must clear state at once.
        rst = 1'b1;
        #1;
        q.push_back('{name: "async_r6", exp: 32'h0});
        e = q.pop_front(); checks++;
        if (a_d0 !== e.exp) begin errors++; $display("FAIL %s: got %h want %h", e.name, a_d0, e.exp); end
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hAAAA;
        step();
        step();
        wr_en = 1'b0;
        rst = 1'b0;
        #2;
        q.push_back('{name: "rst_midwrite_r5", exp: 32'h0});
        q.push_back('{name: "rst_midwrite_r5_nb", exp: 32'h0});
        e = q.pop_front(); checks++;
        if (a_d1 !== e.exp) begin errors++; $display("FAIL %s: got %h want %h", e.name, a_d1, e.exp); end
        e = q.pop_front(); checks++;
        if (b_d1 !== e.exp) begin errors++; $display("FAIL %s: got %h want %h", e.name, b_d1, e.exp); end
        for (int i = 0; i < 32; i++) mreg[i] = 32'h0;
    endtask

    task automatic test_write_bypass();
        step();
        set_rd(5, 5);
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
        #2;
        q.push_back('{name: "bypass_same_cycle", exp: 32'hDEADBEEF});
        q.push_back('{name: "nobypass_same_cycle", exp: 32'h0});
        e = q.pop_front(); checks++;
        if (a_d0 !== e.exp) begin errors++; $display("FAIL %s: got %h want %h", e.name, a_d0, e.exp); end
        e = q.pop_front(); checks++;
        if (b_d0 !== e.exp) begin errors++; $display("FAIL %s: got %h want %h", e.name, b_d0, e.exp); end
        step();
        wr_en = 1'b0;
        mreg[5] = 32'hDEADBEEF;
        #2;
        q.push_back('{name: "bypass_next_cycle", exp: mreg[5]});
        q.push_back('{name: "nobypass_next_cycle", exp: mreg[5]});
        e = q.pop_front(); checks++;
        if (a_d0 !== e.exp) begin errors++; $display("FAIL %s: got %h want %h", e.name, a_d0, e.exp); end
        e = q.pop_front(); checks++;
        if (b_d0 !== e.exp) begin errors++; $display("FAIL %s: got %h want %h", e.name, b_d0, e.exp); end
    endtask

    task automatic test_zero_reg();
        step();
        set_rd(0, 0);
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFFFFFF;
        issue_en = 1'b1; issue_addr = 5'd0;
        #2;
        q.push_back('{name: "r0_issue_ready", exp: 32'h1});
        q.push_back('{name: "r0_no_bypass", exp: 32'h0});
        e = q.pop_front(); checks++;
        if ({31'b0, ready_a} !== e.exp) begin errors++; $display("FAIL %s: got %h want %h", e.name, ready_a, e.exp); end
        e = q.pop_front(); checks++;
        if (a_d0 !== e.exp) begin errors++; $display("FAIL %s: got %h want %h", e.name, a_d0, e.exp); end
        step();
        wr_en = 1'b0; issue_en = 1'b0;
        #2;
        q.push_back('{name: "r0_data", exp: 32'h0});
        q.push_back('{name: "r0_busy", exp: 32'h0});
        q.push_back('{name: "r0_count", exp: 32'h0});
        e = q.pop_front(); checks++;
        if (a_d0 !== e.exp) begin errors++; $display("FAIL %s: got %h want %h", e.name, a_d0, e.exp); end
        e = q.pop_front(); checks++;
        if ({31'b0, rd_busy_a[0]} !== e.exp) begin errors++; $display("FAIL %s: got %h want %h", e.name, rd_busy_a[0], e.exp); end
        e = q.pop_front(); checks++;
        if ({26'b0, count_a} !== e.exp) begin errors++; $display("FAIL %s: got %h want %h", e.name, count_a, e.exp); end

        wr_en = 1'b1; wr_addr = 5'd20; wr_data = 32'h77;
        step();
        wr_en = 1'b0;
        mreg[20] = 32'h77;
        set_rd(0, 20);
        #2;
        q.push_back('{name: "oob_r20_data", exp: 32'h0});
        q.push_back('{name: "oob_r20_busy", exp: 32'h0});
        q.push_back('{name: "r20_in_32reg", exp: mreg[20]});
        e = q.pop_front(); checks++;
        if (c_d1 !== e.exp) begin errors++; $display("FAIL %s: got %h want %h", e.name, c_d1, e.exp); end
        e = q.pop_front(); checks++;
        if ({31'b0, rd_busy_c[1]} !== e.exp) begin errors++; $display("FAIL %s: got %h want %h", e.name, rd_busy_c[1], e.exp); end
        e = q.pop_front(); checks++;
        if (a_d1 !== e.exp) begin errors++; $display("FAIL %s: got %h want %h", e.name, a_d1, e.exp); end
    endtask

    task automatic test_issue();
        step();
        set_rd(0, 3);
        issue_en = 1'b1; issue_addr = 5'd3;
        #2;
        q.push_back('{name: "iss_r3_ready", exp: 32'h1});
        q.push_back('{name: "iss_r3_busy_same_cycle", exp: 32'h0});
        e = q.pop_front(); checks++;
        if ({31'b0, ready_a} !== e.exp) begin errors++; $display("FAIL %s: got %h want %h", e.name, ready_a, e.exp); end
        e = q.pop_front(); checks++;
        if ({31'b0, rd_busy_a[1]} !== e.exp) begin errors++; $display("FAIL %s: got %h want %h", e.name, rd_busy_a[1], e.exp); end
        step();
        issue_en = 1'b0;
        #2;
        q.push_back('{name: "iss_r3_busy", exp: 32'h1});
        q.push_back('{name: "iss_r3_count", exp: 32'h1});
        e = q.pop_front(); checks++;
        if ({31'b0, rd_busy_a[1]} !== e.exp) begin errors++; $display("FAIL %s: got %h want %h", e.name, rd_busy_a[1], e.exp); end
        e = q.pop_front(); checks++;
        if ({26'b0, count_a} !== e.exp) begin errors++; $display("FAIL %s: got %h want %h", e.name, count_a, e.exp); end
        issue_en = 1'b1;
        #1;
        q.push_back('{name: "reissue_r3_ready", exp: 32'h0});
        e = q.pop_front(); checks++;
        if ({31'b0, ready_a} !== e.exp) begin errors++; $display("FAIL %s: got %h want %h", e.name, ready_a, e.exp); end
        step();
        issue_en = 1'b0;
        #2;
        q.push_back('{name: "dropped_issue_count", exp: 32'h1});
        e = q.pop_front(); checks++;
        if ({26'b0, count_a} !== e.exp) begin errors++; $display("FAIL %s: got %h want %h", e.name, count_a, e.exp); end
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h7;
        #1;
        q.push_back('{name: "wb_r3_busy_same_cycle", exp: 32'h0});
        q.push_back('{name: "wb_r3_ready_same_cycle", exp: 32'h1});
        q.push_back('{name: "wb_r3_data_bypass", exp: 32'h7});
        e = q.pop_front(); checks++;
        if ({31'b0, rd_busy_a[1]} !== e.exp) begin errors++; $display("FAIL %s: got %h want %h", e.name, rd_busy_a[1], e.exp); end
        e = q.pop_front(); checks++;
        if ({31'b0, ready_a} !== e.exp) begin errors++; $display("FAIL %s: got %h want %h", e.name, ready_a, e.exp); end
        e = q.pop_front(); checks++;
        if (a_d1 !== e.exp) begin errors++; $display("FAIL %s: got %h want %h", e.name, a_d1, e.exp); end
        step();
        wr_en = 1'b0;
        mreg[3] = 32'h7;
        #2;
        q.push_back('{name: "wb_r3_count", exp: 32'h0});
        q.push_back('{name: "wb_r3_busy", exp: 32'h0});
        e = q.pop_front(); checks++;
        if ({26'b0, count_a} !== e.exp) begin errors++; $display("FAIL %s: got %h want %h", e.name, count_a, e.exp); end
        e = q.pop_front(); checks++;
        if ({31'b0, rd_busy_b[1]} !== e.exp) begin errors++; $display("FAIL %s: got %h want %h", e.name, rd_busy_b[1], e.exp); end
    endtask

    task automatic test_issue_write_same();
        step();
        set_rd(4, 3);
        issue_en = 1'b1; issue_addr = 5'd3;
        step();
        issue_en = 1'b0;
        #2;
        issue_en = 1'b1; issue_addr = 5'd3;
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h9;
        #1;
        q.push_back('{name: "same_ready", exp: 32'h1});
        e = q.pop_front(); checks++;
        if ({31'b0, ready_a} !== e.exp) begin errors++; $display("FAIL %s: got %h want %h", e.name, ready_a, e.exp); end
        step();
        issue_en = 1'b0; wr_en = 1'b0;
        mreg[3] = 32'h9;
        #2;
        q.push_back('{name: "same_r3_data", exp: mreg[3]});
        q.push_back('{name: "same_r3_busy", exp: 32'h1});
        q.push_back('{name: "same_count", exp: 32'h1});
        e = q.pop_front(); checks++;
        if (a_d1 !== e.exp) begin errors++; $display("FAIL %s: got %h want %h", e.name, a_d1, e.exp); end
        e = q.pop_front(); checks++;
        if ({31'b0, rd_busy_a[1]} !== e.exp) begin errors++; $display("FAIL %s: got %h want %h", e.name, rd_busy_a[1], e.exp); end
        e = q.pop_front(); checks++;
        if ({26'b0, count_a} !== e.exp) begin errors++; $display("FAIL %s: got %h want %h", e.name, count_a, e.exp); end

        issue_en = 1'b1; issue_addr = 5'd4;
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'hA;
        step();
        issue_en = 1'b0; wr_en = 1'b0;
        mreg[3] = 32'hA;
        #2;
        q.push_back('{name: "swap_count", exp: 32'h1});
        q.push_back('{name: "swap_r4_busy", exp: 32'h1});
        q.push_back('{name: "swap_r3_busy", exp: 32'h0});
        q.push_back('{name: "swap_r3_data", exp: mreg[3]});
        e = q.pop_front(); checks++;
        if ({26'b0, count_a} !== e.exp) begin errors++; $display("FAIL %s: got %h want %h", e.name, count_a, e.exp); end
        e = q.pop_front(); checks++;
        if ({31'b0, rd_busy_a[0]} !== e.exp) begin errors++; $display("FAIL %s: got %h want %h", e.name, rd_busy_a[0], e.exp); end
        e = q.pop_front(); checks++;
        if ({31'b0, rd_busy_a[1]} !== e.exp) begin errors++; $display("FAIL %s: got %h want %h", e.name, rd_busy_a[1], e.exp); end
        e = q.pop_front(); checks++;
        if (a_d1 !== e.exp) begin errors++; $display("FAIL %s: got %h want %h", e.name, a_d1, e.exp); end

        wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'h44;
        step();
        wr_en = 1'b0;
        mreg[4] = 32'h44;
        #2;
        q.push_back('{name: "release_r4_count", exp: 32'h0});
        e = q.pop_front(); checks++;
        if ({26'b0, count_a} !== e.exp) begin errors++; $display("FAIL %s: got %h want %h", e.name, count_a, e.exp); end
    endtask

    task automatic test_back_to_back();
        step();
        issue_en = 1'b1;
        for (int r = 1; r < 32; r++) begin
            issue_addr = 5'(r);
            step();
        end
        issue_en = 1'b0;
        mcount = 31;
        #2;
        q.push_back('{name: "fill_count", exp: 32'(mcount)});
        q.push_back('{name: "fill_count_nb", exp: 32'(mcount)});
        q.push_back('{name: "fill_count_16", exp: 32'd15});
        e = q.pop_front(); checks++;
        if ({26'b0, count_a} !== e.exp) begin errors++; $display("FAIL %s: got %h want %h", e.name, count_a, e.exp); end
        e = q.pop_front(); checks++;
        if ({26'b0, count_b} !== e.exp) begin errors++; $display("FAIL %s: got %h want %h", e.name, count_b, e.exp); end
        e = q.pop_front(); checks++;
        if ({26'b0, count_c} !== e.exp) begin errors++; $display("FAIL %s: got %h want %h", e.name, count_c, e.exp); end

        for (int r = 31; r >= 1; r--) begin
            wr_en = 1'b1; wr_addr = 5'(r); wr_data = 32'hC0DE_0000 + 32'(r);
            step();
            mreg[r] = 32'hC0DE_0000 + 32'(r);
            mcount--;
            #1;
            q.push_back('{name: "drain_count", exp: 32'(mcount)});
            e = q.pop_front(); checks++;
            if ({26'b0, count_a} !== e.exp) begin errors++; $display("FAIL %s r=%0d: got %h want %h", e.name, r, count_a, e.exp); end
        end
        wr_addr = 5'd1; wr_data = 32'h1111;
        step();
        wr_en = 1'b0;
        mreg[1] = 32'h1111;
        #1;
        q.push_back('{name: "no_underflow", exp: 32'h0});
        q.push_back('{name: "drain_count_16", exp: 32'h0});
        e = q.pop_front(); checks++;
        if ({26'b0, count_a} !== e.exp) begin errors++; $display("FAIL %s: got %h want %h", e.name, count_a, e.exp); end
        e = q.pop_front(); checks++;
        if ({26'b0, count_c} !== e.exp) begin errors++; $display("FAIL %s: got %h want %h", e.name, count_c, e.exp); end

        for (int a = 0; a < 32; a++) begin
            set_rd(a, 31 - a);
            #1;
            q.push_back('{name: "final_rd0", exp: mreg[a]});
            q.push_back('{name: "final_rd1_nb", exp: mreg[31 - a]});
            q.push_back('{name: "final_rd0_16", exp: (a < 16) ? mreg[a] : 32'h0});
            e = q.pop_front(); checks++;
            if (a_d0 !== e.exp) begin errors++; $display("FAIL %s a=%0d: got %h want %h", e.name, a, a_d0, e.exp); end
            e = q.pop_front(); checks++;
            if (b_d1 !== e.exp) begin errors++; $display("FAIL %s a=%0d: got %h want %h", e.name, 31 - a, b_d1, e.exp); end
            e = q.pop_front(); checks++;
            if (c_d0 !== e.exp) begin errors++; $display("FAIL %s a=%0d: got %h want %h", e.name, a, c_d0, e.exp); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #2;
        test_reset();
        test_write_bypass();
        test_zero_reg();
        test_issue();
        test_issue_write_same();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_file_sb.md
# reg_file_sb

Parametrised register file for the datapath with N asynchronous read ports, one synchronous write-back port, optional same-cycle write-to-read bypass, and a per-register busy scoreboard for multi-cycle producers. It replaces the fixed 32-bit, two-read register file. It sits between decode, which reads operands and reserves destinations, and write-back, which writes results and releases destinations.

## Interface
Parameters:
- DATA_W, default 32: register width in bits.
- ADDR_W, default 5: register address width.
- NUM_REGS, default 32: number of implemented registers. Must be ≤ 2**ADDR_W.
- NUM_RD, default 2: number of read ports.
- BYPASS, default 1: 1 forwards same-cycle write data to the read ports.
- ZERO_REG, default 1: 1 makes R0 hardwired to zero, never written and never busy.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- rd_addr  in  NUM_RD*ADDR_W  packed read addresses; port i is bits [i*ADDR_W +: ADDR_W].
- rd_data  out  NUM_RD*DATA_W  packed read data.
- rd_busy  out  NUM_RD  1 when the addressed register has a pending producer.
- wr_en  in  1  write-back strobe.
- wr_addr  in  ADDR_W  write-back destination.
- wr_data  in  DATA_W  write-back value.
- issue_en  in  1  request to reserve issue_addr as busy.
- issue_addr  in  ADDR_W  destination to reserve.
- issue_ready  out  1  the reservation can be accepted this cycle.
- busy_count  out  ADDR_W+1  number of currently busy registers.

## Operation
- Valid address: below NUM_REGS, and not 0 when ZERO_REG=1.
- Invalid addresses:
  - Reads return 0 with rd_busy=0.
  - Writes are ignored.
  - Issue has no effect and issue_ready=1.
- Write: when wr_en and wr_addr is valid, regs[wr_addr] <= wr_data and busy[wr_addr] <= 0.
- Read (combinational), per port:
  - If BYPASS=1, wr_en, and wr_addr == rd_addr (valid address): rd_data = wr_data, rd_busy = 0.
  - Otherwise: rd_data = regs[rd_addr], rd_busy = busy[rd_addr].
- Issue handshake:
  - issue_ready = !busy[issue_addr] || (wr_en && wr_addr == issue_addr).
  - The reservation is accepted when issue_en && issue_ready: busy[issue_addr] <= 1.
  - issue_en with issue_ready=0 is dropped. The requester must hold issue_en until it is accepted.
- Issue and write to the same register in the same cycle: the register takes wr_data and busy ends the cycle at 1, because the new producer wins.
- busy_count update each cycle, with inc = accepted issue and dec = valid write to a register that was busy (not re-reserved in the same cycle):
  - inc and dec together: no change.
  - inc only: +1.
  - dec only: −1.
  - Never wraps. Range is 0..NUM_REGS.
- A write to a non-busy register is legal: the data is updated and the count is unchanged.

## Timing
- Reset (asynchronous, active-high):
  - All regs are 0, all busy bits 0, busy_count 0.
  - rd_data is 0 and rd_busy is 0 for any address. issue_ready is 1.
- Reset takes effect immediately regardless of clk, and overrides any write or issue in flight. The first update happens on the first rising edge after rst is deasserted.
- Read latency: 0 cycles (combinational).
- Write visibility:
  - BYPASS=1: the written value appears on rd_data in the same cycle as the write.
  - BYPASS=0: it appears from the cycle after the edge.
- Busy set by an accepted issue is visible on rd_busy and issue_ready from the next cycle.
- Busy clear by a write is visible in the same cycle via bypass and issue_ready, and in the registered state after the edge.

## Structure
- Shared package reg_file_pkg holds:
  - default constants DATA_W_DEF=32, ADDR_W_DEF=5, NUM_REGS_DEF=32;
  - the function addr_valid(addr, NUM_REGS, ZERO_REG).
- Sub-module reg_scoreboard holds the busy vector, the issue_ready logic and the busy_count counter. Its inputs are the issue and write strobes and addresses; its outputs are the busy vector, issue_ready and busy_count.
- Top level holds the data array, the read muxes and bypass, instantiated once per port with a generate loop.

## Test plan
- Reset, then read all addresses on both ports → rd_data=0, rd_busy=0, busy_count=0. Assert rst mid-write → regs stay 0.
- Write R5=0xDEADBEEF while port 0 reads R5:
  - BYPASS=1: port 0 shows 0xDEADBEEF in the same cycle.
  - BYPASS=0: the old value this cycle, 0xDEADBEEF from the next cycle.
- ZERO_REG=1: write R0=0xFFFFFFFF, issue R0 → R0 reads 0, rd_busy=0, busy_count=0. An address ≥ NUM_REGS (NUM_REGS=16, addr 20) reads 0.
- Issue R3 → next cycle rd_busy=1, busy_count=1, and issue R3 again gives issue_ready=0. Write R3=7 → same cycle rd_busy=0, issue_ready=1, and busy_count=0 after the edge.
- Same cycle issue R3 and write R3=9 (with R3 busy) → R3 reads 9, busy stays 1, busy_count unchanged. Issue R4 while writing R3 → busy_count unchanged.
- Issue all 31 valid registers → busy_count=31. Write them all back in reverse order → busy_count=0, never underflowing.
